axi4m_wr_adp: RTL and testbench
===============================

Name: axi4m_wr_adp

Overview:
Per-DDR AXI4 write master adapter. It is the write-direction counterpart of the per-DDR read adapter in the MMU RX path.
- Accepts write commands (address + burst length) and 512-bit data beats from the MMU TX logic through push-style FIFO interfaces.
- Issues AXI4 AW/W bursts to one DDR controller, tracks B responses and reports sticky timeout/error status.
- Instantiated once per DDR inside a generate loop.

Parameters:
CMD_FF_DEPTH, 16, command FIFO depth (power of 2)
DAT_FF_DEPTH, 64, data FIFO depth in beats (power of 2)
MAX_OST, 8, max outstanding AW bursts awaiting B
AXI_ID, 4'd0, constant AWID; expected BID

Ports:
clk_sys in 1 system clock
rst in 1 synchronous active-high reset
wcmd_ff_wen in 1 push command
wcmd_ff_wdata in 72 [63:0] byte address, [71:64] AXI len (beats-1)
wcmd_ff_full in→out, out 1 command FIFO almost full
wdat_ff_wen in 1 push data beat
wdat_ff_wdata in 577 [511:0] data, [575:512] strobe, [576] last-of-burst marker
wdat_ff_full out 1 data FIFO almost full
awid/awaddr/awlen/awsize/awburst out 4/64/8/3/2 AXI4 write address
awvalid out 1; awready in 1
wdata/wstrb/wlast out 512/64/1; wvalid out 1; wready in 1
bid in 4; bresp in 2; bvalid in 1; bready out 1
reg_tmout_us_cfg in 16 timeout in µs; 0 disables
reg_timer_1us_cfg in 8 clk_sys cycles per µs minus 1
cnt_reg_clr in 1 clears sticky error bits
reg_axi_tmout_err out 4 sticky: [0] AW timeout, [1] W timeout/last mismatch, [2] B timeout, [3] BRESP≠OKAY or BID≠AXI_ID

Behaviour:
- Reset:
  - awvalid, wvalid, wlast, bready, reg_axi_tmout_err = 0; all other AXI outputs = 0.
  - FIFOs empty; outstanding count, beat counter and timers = 0.
  - Reset mid-burst abandons the burst with no further AXI activity.
- Full flags: asserted when fill ≥ depth-2, which tolerates one registered push in flight. A push when the FIFO is truly full is dropped and sets err[1].
- AW path:
  - Pop a command when the cmd FIFO is non-empty, awvalid=0, outstanding<MAX_OST and the len queue is not full.
  - Register awaddr/awlen from the popped command; awsize=3'b110, awburst=2'b01, awid=AXI_ID.
  - awvalid rises the cycle after the pop and holds with stable fields until awready.
  - On the AW handshake, push awlen into an internal len queue (depth MAX_OST) and increment outstanding.
- W path FSM:
  - W_IDLE: leave when the len queue is non-empty; load the beat counter with 0.
  - W_DATA: wvalid = data FIFO non-empty; a beat pops only on wvalid&wready.
  - wlast = (beat counter == current len). wdata/wstrb come straight from the FIFO head (first-word-fall-through).
  - On a wlast handshake, pop the len queue. Go to W_IDLE if it is now empty, else stay in W_DATA with the counter reset to 0.
  - If the FIFO last marker ≠ the computed wlast on any handshake beat, set err[1]. The computed wlast wins.
  - W never starts before its AW handshake.
- B path:
  - bready is tied to 1 outside reset.
  - bvalid decrements outstanding. A simultaneous AW handshake and bvalid leaves outstanding unchanged.
  - bvalid with outstanding==0 sets err[3] and does not underflow.
  - bresp≠0 or bid≠AXI_ID sets err[3].
- Timers:
  - The µs prescaler wraps at reg_timer_1us_cfg and produces a 1-cycle tick.
  - One µs counter per condition: awvalid&!awready; wvalid&!wready, or W_DATA with the FIFO empty; outstanding>0 with no bvalid.
  - Each counter clears when its condition drops or on its handshake. When it reaches reg_tmout_us_cfg (≠0), set the matching sticky bit once; the counter saturates.
- Sticky bits clear on cnt_reg_clr. A set event in the same cycle as cnt_reg_clr wins.

Decomposition:
Shared package:
- Command field offsets (ADDR 63:0, LEN 71:64) and data field offsets (DATA, STRB, LAST).
- AXI_SIZE_64B = 3'b110, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
- Error bit indices.
- W FSM state encoding.

Sub-module `wr_adp_sfifo`:
- Parameterised width/depth, first-word-fall-through, with almost-full and count.
- Instantiated for cmd, data and the len queue.

Test Plan:
1. Single burst: push cmd addr=0x1000 len=3 plus 4 beats, awready=wready=1 → AW at 0x1000 len 3 one cycle after pop, 4 W beats with wlast on beat 4; BRESP OKAY → outstanding 0, err=0.
2. Back-pressure: awready low 10 cycles, wready toggling 1/0 → fields stable while valid, exactly 4 W handshakes, no W before AW.
3. Outstanding limit: 9 cmds len=0 with bvalid withheld → exactly 8 AW handshakes; the 9th is issued one cycle after the first bvalid.
4. Timeout: reg_timer_1us_cfg=9, reg_tmout_us_cfg=2, bvalid withheld → err[2] set after ~20 cycles; cnt_reg_clr → 0.
5. Last mismatch: len=1 with the data marker on beat 1 → wlast on beat 2 as computed, err[1]=1.
6. Error responses: bresp=2'b10 → err[3]=1. Simultaneous AW handshake and bvalid → outstanding unchanged. Reset mid-burst → all valids 0 next cycle.

Source files
------------

// File: rtl/axi4m_wr_adp_pkg.sv
// Shared definitions for the per-DDR AXI4 write master adapter.
// Contents: command/data FIFO word layouts, fixed AXI encodings,
// sticky error bit indices and the W-channel FSM state encoding.
package axi4m_wr_adp_pkg;

  // Command word: [63:0] byte address, [71:64] AXI len (beats-1)
  localparam int CMD_W        = 72;
  localparam int CMD_ADDR_LSB = 0;
  localparam int CMD_ADDR_MSB = 63;
  localparam int CMD_LEN_LSB  = 64;
  localparam int CMD_LEN_MSB  = 71;

  // Data word: [511:0] data, [575:512] strobe, [576] last-of-burst marker
  localparam int DAT_W        = 577;
  localparam int DAT_DATA_LSB = 0;
  localparam int DAT_DATA_MSB = 511;
  localparam int DAT_STRB_LSB = 512;
  localparam int DAT_STRB_MSB = 575;
  localparam int DAT_LAST_BIT = 576;

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Sticky error bit positions in reg_axi_tmout_err
  localparam int ERR_AW   = 0;
  localparam int ERR_W    = 1;
  localparam int ERR_B    = 2;
  localparam int ERR_RESP = 3;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_e;

endpackage

// File: rtl/wr_adp_sfifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: wr_en/wr_data push; rd_en pops the head shown on rd_data;
// empty/full are exact, afull asserts at count >= DEPTH-2 so a producer
// with one registered push in flight never overruns; count is the fill.
// A push while full and a pop while empty are ignored.
module wr_adp_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] AFULL_C = (PW+1)'(DEPTH - 2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_s, pop_s;

  // Qualified push/pop and next pointer/count values
  always_comb begin
    push_s   = wr_en && (cnt_q != DEPTH_C);
    pop_s    = rd_en && (cnt_q != {(PW+1){1'b0}});
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    if (push_s && !pop_s) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and fill-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {(PW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (cnt_q == {(PW+1){1'b0}});
  assign full    = (cnt_q == DEPTH_C);
  assign afull   = (cnt_q >= AFULL_C);
  assign count   = cnt_q;

endmodule

// File: rtl/axi4m_wr_adp.sv
// Per-DDR AXI4 write master adapter.
// Ports: wcmd_ff_* push write commands (address + len), wdat_ff_* push
// 512-bit beats with strobe and last marker; *_full are almost-full flags.
// aw*/w*/b* form the AXI4 write master toward one DDR controller.
// reg_timer_1us_cfg sets the microsecond prescaler, reg_tmout_us_cfg the
// stall timeout (0 disables); reg_axi_tmout_err holds sticky error bits
// cleared by cnt_reg_clr.
module axi4m_wr_adp
  import axi4m_wr_adp_pkg::*;
#(
  parameter int         CMD_FF_DEPTH = 16,
  parameter int         DAT_FF_DEPTH = 64,
  parameter int         MAX_OST      = 8,
  parameter logic [3:0] AXI_ID       = 4'd0
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              wcmd_ff_wen,
  input  logic [71:0]       wcmd_ff_wdata,
  output logic              wcmd_ff_full,
  input  logic              wdat_ff_wen,
  input  logic [576:0]      wdat_ff_wdata,
  output logic              wdat_ff_full,
  output logic [3:0]        awid,
  output logic [63:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [511:0]      wdata,
  output logic [63:0]       wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  input  logic [15:0]       reg_tmout_us_cfg,
  input  logic [7:0]        reg_timer_1us_cfg,
  input  logic              cnt_reg_clr,
  output logic [3:0]        reg_axi_tmout_err
);

  localparam int OST_W = $clog2(MAX_OST + 1);
  localparam int CCW   = $clog2(CMD_FF_DEPTH) + 1;
  localparam int DCW   = $clog2(DAT_FF_DEPTH) + 1;
  localparam int LCW   = $clog2(MAX_OST) + 1;

  logic [CMD_W-1:0] cmd_head_s;
  logic             cmd_empty_s, cmd_full_s;
  logic [CCW-1:0]   cmd_cnt_s;
  logic [DAT_W-1:0] dat_head_s;
  logic             dat_empty_s, dat_full_s;
  logic [DCW-1:0]   dat_cnt_s;
  logic [7:0]       len_head_s;
  logic             len_empty_s, len_full_s, len_afull_s;
  logic [LCW-1:0]   len_cnt_s;
  logic             unused_ok_s;

  logic             aw_pop_s, aw_hs_s, w_hs_s, b_evt_s, b_dec_s;
  logic             wvalid_s, wlast_s, tick_s;
  logic [2:0]       cond_s, hit_s;
  logic [3:0]       err_set_s;

  logic             awvalid_q, awvalid_d;
  logic [63:0]      awaddr_q, awaddr_d;
  logic [7:0]       awlen_q, awlen_d;
  logic [2:0]       awsize_q, awsize_d;
  logic [1:0]       awburst_q, awburst_d;
  logic [3:0]       awid_q, awid_d;
  logic [OST_W-1:0] ost_q, ost_d;
  logic             bready_q;
  w_state_e         w_state_q, w_state_d;
  logic [7:0]       beat_q, beat_d;
  logic [7:0]       pre_q, pre_d;
  logic [15:0]      tmo_q [3];
  logic [15:0]      tmo_d [3];
  logic [3:0]       err_q, err_d;

  wr_adp_sfifo #(.WIDTH(CMD_W), .DEPTH(CMD_FF_DEPTH)) u_cmd_ff (
    .clk(clk_sys), .rst(rst), .wr_en(wcmd_ff_wen), .wr_data(wcmd_ff_wdata),
    .rd_en(aw_pop_s), .rd_data(cmd_head_s), .empty(cmd_empty_s),
    .full(cmd_full_s), .afull(wcmd_ff_full), .count(cmd_cnt_s)
  );

  wr_adp_sfifo #(.WIDTH(DAT_W), .DEPTH(DAT_FF_DEPTH)) u_dat_ff (
    .clk(clk_sys), .rst(rst), .wr_en(wdat_ff_wen), .wr_data(wdat_ff_wdata),
    .rd_en(w_hs_s), .rd_data(dat_head_s), .empty(dat_empty_s),
    .full(dat_full_s), .afull(wdat_ff_full), .count(dat_cnt_s)
  );

  // Lengths of AW bursts already accepted, consumed in order by the W FSM
  wr_adp_sfifo #(.WIDTH(8), .DEPTH(MAX_OST)) u_len_ff (
    .clk(clk_sys), .rst(rst), .wr_en(aw_hs_s), .wr_data(awlen_q),
    .rd_en(w_hs_s && wlast_s), .rd_data(len_head_s), .empty(len_empty_s),
    .full(len_full_s), .afull(len_afull_s), .count(len_cnt_s)
  );

  assign unused_ok_s = ^{cmd_cnt_s, dat_cnt_s, len_afull_s};

  // Channel handshakes and the command pop qualifier
  always_comb begin
    aw_hs_s  = awvalid_q && awready;
    w_hs_s   = wvalid_s && wready;
    b_evt_s  = bvalid && bready_q;
    b_dec_s  = b_evt_s && (ost_q != {OST_W{1'b0}});
    aw_pop_s = !cmd_empty_s && !awvalid_q && !len_full_s &&
               (ost_q < OST_W'(MAX_OST));
  end

  // AW channel: load on pop, hold until accepted; outstanding bookkeeping
  always_comb begin
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    awid_d    = awid_q;
    awvalid_d = awvalid_q;
    if (aw_pop_s) begin
      awaddr_d  = cmd_head_s[CMD_ADDR_MSB:CMD_ADDR_LSB];
      awlen_d   = cmd_head_s[CMD_LEN_MSB:CMD_LEN_LSB];
      awsize_d  = AXI_SIZE_64B;
      awburst_d = AXI_BURST_INCR;
      awid_d    = AXI_ID;
      awvalid_d = 1'b1;
    end else if (aw_hs_s) begin
      awvalid_d = 1'b0;
    end else begin
      awvalid_d = awvalid_q;
    end
    case ({aw_hs_s, b_dec_s})
      2'b10:   ost_d = ost_q + OST_W'(1);
      2'b01:   ost_d = ost_q - OST_W'(1);
      default: ost_d = ost_q;
    endcase
  end

  // W FSM next state and beat counter
  always_comb begin
    w_state_d = w_state_q;
    beat_d    = beat_q;
    case (w_state_q)
      W_IDLE: begin
        if (!len_empty_s) begin
          w_state_d = W_DATA;
          beat_d    = 8'd0;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s && wlast_s) begin
          beat_d = 8'd0;
          // A length pushed this cycle keeps the queue non-empty
          if ((len_cnt_s > LCW'(1)) || aw_hs_s) begin
            w_state_d = W_DATA;
          end else begin
            w_state_d = W_IDLE;
          end
        end else if (w_hs_s) begin
          beat_d = beat_q + 8'd1;
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        beat_d    = 8'd0;
      end
    endcase
  end

  // W FSM outputs; the computed wlast overrides the FIFO marker
  always_comb begin
    if (w_state_q == W_DATA) begin
      wvalid_s = !dat_empty_s;
      wlast_s  = (beat_q == len_head_s);
    end else begin
      wvalid_s = 1'b0;
      wlast_s  = 1'b0;
    end
  end

  // Stall conditions watched by the microsecond timeout counters
  always_comb begin
    tick_s    = (pre_q >= reg_timer_1us_cfg);
    pre_d     = tick_s ? 8'd0 : (pre_q + 8'd1);
    cond_s[0] = awvalid_q && !awready;
    cond_s[1] = (wvalid_s && !wready) || ((w_state_q == W_DATA) && dat_empty_s);
    cond_s[2] = (ost_q != {OST_W{1'b0}}) && !bvalid;
  end

  // Timeout counters: clear when idle, saturate at the limit, flag once
  always_comb begin
    hit_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tmo_d[i] = tmo_q[i];
      if (!cond_s[i]) begin
        tmo_d[i] = 16'd0;
      end else if (tick_s && (tmo_q[i] != reg_tmout_us_cfg)) begin
        tmo_d[i] = tmo_q[i] + 16'd1;
        hit_s[i] = (reg_tmout_us_cfg != 16'd0) && (tmo_d[i] == reg_tmout_us_cfg);
      end else begin
        tmo_d[i] = tmo_q[i];
      end
    end
  end

  // Sticky error collection; a new event beats a simultaneous clear
  always_comb begin
    err_set_s           = 4'b0000;
    err_set_s[ERR_AW]   = hit_s[0];
    err_set_s[ERR_W]    = hit_s[1] ||
                          (wcmd_ff_wen && cmd_full_s) ||
                          (wdat_ff_wen && dat_full_s) ||
                          (w_hs_s && (dat_head_s[DAT_LAST_BIT] != wlast_s));
    err_set_s[ERR_B]    = hit_s[2];
    err_set_s[ERR_RESP] = b_evt_s && ((bresp != AXI_RESP_OKAY) || (bid != AXI_ID) ||
                                      (ost_q == {OST_W{1'b0}}));
    if (cnt_reg_clr) begin
      err_d = err_set_s;
    end else begin
      err_d = err_q | err_set_s;
    end
  end

  // State registers
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      awaddr_q  <= 64'd0;
      awlen_q   <= 8'd0;
      awsize_q  <= 3'd0;
      awburst_q <= 2'd0;
      awid_q    <= 4'd0;
      ost_q     <= {OST_W{1'b0}};
      bready_q  <= 1'b0;
      w_state_q <= W_IDLE;
      beat_q    <= 8'd0;
      pre_q     <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        tmo_q[i] <= 16'd0;
      end
      err_q     <= 4'd0;
    end else begin
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      awid_q    <= awid_d;
      ost_q     <= ost_d;
      bready_q  <= 1'b1;
      w_state_q <= w_state_d;
      beat_q    <= beat_d;
      pre_q     <= pre_d;
      for (int i = 0; i < 3; i++) begin
        tmo_q[i] <= tmo_d[i];
      end
      err_q     <= err_d;
    end
  end

  assign awvalid           = awvalid_q;
  assign awaddr            = awaddr_q;
  assign awlen             = awlen_q;
  assign awsize            = awsize_q;
  assign awburst           = awburst_q;
  assign awid              = awid_q;
  assign wvalid            = wvalid_s;
  assign wlast             = wlast_s;
  assign wdata             = wvalid_s ? dat_head_s[DAT_DATA_MSB:DAT_DATA_LSB] : 512'd0;
  assign wstrb             = wvalid_s ? dat_head_s[DAT_STRB_MSB:DAT_STRB_LSB] : 64'd0;
  assign bready            = bready_q;
  assign reg_axi_tmout_err = err_q;

endmodule

// File: tb/tb_axi4m_wr_adp.sv
// Scoreboard bench for axi4m_wr_adp: stimulus tasks push expected AW and W
// items into queues, a negedge monitor pops and compares on handshakes,
// and a B responder answers accepted bursts.
module tb_axi4m_wr_adp;

  localparam logic [3:0] AXI_ID = 4'd0;

  logic         clk_sys = 1'b0;
  logic         rst = 1'b1;
  logic         wcmd_ff_wen = 1'b0;
  logic [71:0]  wcmd_ff_wdata = 72'd0;
  logic         wcmd_ff_full;
  logic         wdat_ff_wen = 1'b0;
  logic [576:0] wdat_ff_wdata = 577'd0;
  logic         wdat_ff_full;
  logic [3:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [3:0]   bid = 4'd0;
  logic [1:0]   bresp = 2'd0;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [15:0]  reg_tmout_us_cfg = 16'd0;
  logic [7:0]   reg_timer_1us_cfg = 8'd3;
  logic         cnt_reg_clr = 1'b0;
  logic [3:0]   reg_axi_tmout_err;

  always #5 clk_sys = ~clk_sys;

  axi4m_wr_adp #(.CMD_FF_DEPTH(16), .DAT_FF_DEPTH(64), .MAX_OST(8), .AXI_ID(4'd0)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .wcmd_ff_wen(wcmd_ff_wen), .wcmd_ff_wdata(wcmd_ff_wdata), .wcmd_ff_full(wcmd_ff_full),
    .wdat_ff_wen(wdat_ff_wen), .wdat_ff_wdata(wdat_ff_wdata), .wdat_ff_full(wdat_ff_full),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .reg_tmout_us_cfg(reg_tmout_us_cfg), .reg_timer_1us_cfg(reg_timer_1us_cfg),
    .cnt_reg_clr(cnt_reg_clr), .reg_axi_tmout_err(reg_axi_tmout_err)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [511:0] data; logic [63:0] strb; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  int  errors = 0;
  int  checks = 0;
  int  aw_hs_cnt = 0;
  int  w_burst_cnt = 0;
  int  b_sent_cnt = 0;
  int  rdy_mode = 0;
  int  b_mode = 1;
  int  b_req = 0;
  int  b_ack = 0;
  logic [1:0] b_req_resp = 2'b00;
  logic [3:0] b_req_bid = 4'd0;

  task automatic check(input string nm, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Ready generator
  always @(posedge clk_sys) begin
    #1;
    case (rdy_mode)
      0: begin awready = 1'b1; wready = 1'b1; end
      1: begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
      2: begin awready = 1'b0; wready = ~wready; end
      3: begin awready = 1'b1; wready = 1'b0; end
      4: begin awready = 1'b0; wready = 1'b0; end
      default: begin awready = 1'b1; wready = ~wready; end
    endcase
  end

  // B responder: automatic OKAY replies for accepted bursts, or one-shot requests
  always @(posedge clk_sys) begin
    #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
    bid    = AXI_ID;
    if (rst) begin
      b_sent_cnt = 0;
    end else if (b_req != b_ack) begin
      bvalid = 1'b1;
      bresp  = b_req_resp;
      bid    = b_req_bid;
      b_ack++;
      if (aw_hs_cnt > b_sent_cnt) b_sent_cnt++;
    end else if (b_mode == 1 && aw_hs_cnt > b_sent_cnt && $urandom_range(0, 2) != 0) begin
      bvalid = 1'b1;
      b_sent_cnt++;
    end
  end

  // Monitor: compares every AW/W handshake against the scoreboard
  logic         prev_aw_stall = 1'b0;
  logic [71:0]  prev_aw = 72'd0;
  logic         prev_w_stall = 1'b0;
  logic [576:0] prev_w = 577'd0;
  int           w_beat = 0;
  always @(negedge clk_sys) begin
    if (rst) begin
      exp_aw.delete();
      exp_w.delete();
      aw_hs_cnt = 0;
      w_burst_cnt = 0;
      w_beat = 0;
      prev_aw_stall = 1'b0;
      prev_w_stall = 1'b0;
    end else begin
      if (prev_aw_stall) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, prev_aw});
      if (prev_w_stall) check("w_hold", {wvalid, wdata, wstrb, wlast}, {1'b1, prev_w});
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          bound_fail("w_unexpected");
        end else begin
          w_t e;
          e = exp_w.pop_front();
          check("w_beat", {wdata, wstrb, wlast}, {e.data, e.strb, e.last});
          if (w_beat == 0) check("w_after_aw", aw_hs_cnt > w_burst_cnt, 1'b1);
          if (e.last) begin
            w_burst_cnt++;
            w_beat = 0;
          end else begin
            w_beat++;
          end
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) begin
          bound_fail("aw_unexpected");
        end else begin
          aw_t a;
          a = exp_aw.pop_front();
          check("aw_fields", {awaddr, awlen}, {a.addr, a.len});
          check("aw_const", {awid, awsize, awburst}, {AXI_ID, 3'b110, 2'b01});
        end
        aw_hs_cnt++;
      end
      prev_aw_stall = awvalid && !awready;
      prev_aw       = {awaddr, awlen};
      prev_w_stall  = wvalid && !wready;
      prev_w        = {wdata, wstrb, wlast};
    end
  end

  task automatic push_cmd(input logic [63:0] a, input logic [7:0] l);
    int n = 0;
    while (wcmd_ff_full && n < 2000) begin tick(1); n++; end
    if (n >= 2000) bound_fail("cmd_full_wait");
    wcmd_ff_wen = 1'b1;
    wcmd_ff_wdata = {l, a};
    exp_aw.push_back('{a, l});
    tick(1);
    wcmd_ff_wen = 1'b0;
  endtask

  task automatic push_beat(input logic marker, input logic exp_last, input bit force_push, input bit kept);
    int n = 0;
    logic [511:0] d;
    logic [63:0] s;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    s = {$urandom, $urandom};
    while (!force_push && wdat_ff_full && n < 2000) begin tick(1); n++; end
    if (n >= 2000) bound_fail("dat_full_wait");
    wdat_ff_wen = 1'b1;
    wdat_ff_wdata = {marker, s, d};
    if (kept) exp_w.push_back('{d, s, exp_last});
    tick(1);
    wdat_ff_wen = 1'b0;
  endtask

  task automatic push_burst(input logic [63:0] a, input logic [7:0] l, input bit bad_marker);
    push_cmd(a, l);
    for (int i = 0; i <= int'(l); i++)
      push_beat(bad_marker ? (i == 0) : (i == int'(l)), i == int'(l), 1'b0, 1'b1);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0 || aw_hs_cnt != b_sent_cnt) && n < 20000) begin
      tick(1);
      n++;
    end
    if (n >= 20000) bound_fail(nm);
    tick(3);
  endtask

  task automatic wait_aw(input int target, input string nm);
    int n = 0;
    while (aw_hs_cnt < target && n < 500) begin tick(1); n++; end
    if (n >= 500) bound_fail(nm);
  endtask

  task automatic clear_err();
    cnt_reg_clr = 1'b1;
    tick(1);
    cnt_reg_clr = 1'b0;
    tick(1);
    check("err_cleared", reg_axi_tmout_err, 4'b0000);
  endtask

  function automatic logic [63:0] rand_addr();
    return {$urandom, $urandom} & ~64'h3f;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    tick(3);
    check("reset_outs", {awvalid, wvalid, wlast, bready, reg_axi_tmout_err, wcmd_ff_full,
                         wdat_ff_full, awaddr, awlen, awsize, awburst}, 0);
    rst = 1'b0;
    tick(1);
    check("bready_after_reset", bready, 1'b1);

    // Single burst, always ready
    push_burst(64'h1000, 8'd3, 1'b0);
    wait_drain("drain_single");
    check("err_single", reg_axi_tmout_err, 4'b0000);

    // AW held off 10 cycles with toggling wready, then random traffic
    rdy_mode = 2;
    push_burst(rand_addr(), 8'd3, 1'b0);
    tick(10);
    rdy_mode = 5;
    wait_drain("drain_backpressure");
    rdy_mode = 1;
    for (int i = 0; i < 24; i++) push_burst(rand_addr(), 8'($urandom_range(0, 7)), 1'b0);
    wait_drain("drain_random");
    check("err_random", reg_axi_tmout_err, 4'b0000);

    // Outstanding count back at zero: a stray B must flag err[3]
    b_req_resp = 2'b00;
    b_req_bid = AXI_ID;
    b_req++;
    tick(3);
    check("err_b_underflow", reg_axi_tmout_err, 4'b1000);
    clear_err();

    // Outstanding limit with B withheld
    rdy_mode = 0;
    b_mode = 0;
    base = aw_hs_cnt;
    for (int i = 0; i < 9; i++) push_burst(rand_addr(), 8'd0, 1'b0);
    tick(30);
    check("ost_limit", aw_hs_cnt - base, 8);
    b_req++;
    tick(8);
    check("ost_release", aw_hs_cnt - base, 9);
    b_mode = 1;
    wait_drain("drain_ost");
    check("err_ost", reg_axi_tmout_err, 4'b0000);

    // B timeout: 10-cycle microsecond, 2 us limit
    reg_timer_1us_cfg = 8'd9;
    reg_tmout_us_cfg = 16'd2;
    b_mode = 0;
    base = aw_hs_cnt;
    push_burst(rand_addr(), 8'd0, 1'b0);
    wait_aw(base + 1, "tmo_aw_wait");
    tick(8);
    check("tmo_early", reg_axi_tmout_err, 4'b0000);
    tick(20);
    check("tmo_b_set", reg_axi_tmout_err, 4'b0100);
    cnt_reg_clr = 1'b1;
    tick(1);
    cnt_reg_clr = 1'b0;
    tick(25);
    check("tmo_saturated", reg_axi_tmout_err, 4'b0000);
    reg_tmout_us_cfg = 16'd0;
    reg_timer_1us_cfg = 8'd3;
    b_mode = 1;
    wait_drain("drain_tmo");
    check("err_after_tmo", reg_axi_tmout_err, 4'b0000);

    // Last marker on the wrong beat
    push_burst(rand_addr(), 8'd1, 1'b1);
    wait_drain("drain_mismatch");
    check("err_last_mismatch", reg_axi_tmout_err, 4'b0010);
    clear_err();

    // Error responses: SLVERR, then wrong BID
    b_mode = 0;
    base = aw_hs_cnt;
    push_burst(rand_addr(), 8'd0, 1'b0);
    wait_aw(base + 1, "bresp_aw_wait");
    tick(2);
    b_req_resp = 2'b10;
    b_req++;
    tick(3);
    check("err_bresp", reg_axi_tmout_err, 4'b1000);
    clear_err();
    push_burst(rand_addr(), 8'd0, 1'b0);
    wait_aw(base + 2, "bid_aw_wait");
    tick(2);
    b_req_resp = 2'b00;
    b_req_bid = 4'd5;
    b_req++;
    tick(3);
    b_req_bid = AXI_ID;
    check("err_bid", reg_axi_tmout_err, 4'b1000);
    clear_err();
    b_mode = 1;
    wait_drain("drain_resp");

    // Data FIFO almost-full threshold and overflow drop
    rdy_mode = 4;
    tick(2);
    for (int i = 0; i < 61; i++) push_beat(i % 8 == 7, i % 8 == 7, 1'b0, 1'b1);
    check("dat_full_61", wdat_ff_full, 1'b0);
    push_beat(1'b0, 1'b0, 1'b0, 1'b1);
    check("dat_full_62", wdat_ff_full, 1'b1);
    push_beat(1'b0, 1'b0, 1'b1, 1'b1);
    push_beat(1'b1, 1'b1, 1'b1, 1'b1);
    check("err_before_overflow", reg_axi_tmout_err, 4'b0000);
    push_beat(1'b0, 1'b0, 1'b1, 1'b0);
    check("err_overflow", reg_axi_tmout_err, 4'b0010);
    clear_err();
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) push_cmd(rand_addr(), 8'd7);
    wait_drain("drain_full");
    check("err_full_drain", reg_axi_tmout_err, 4'b0000);

    // Reset in the middle of a stalled burst
    rdy_mode = 3;
    base = aw_hs_cnt;
    push_burst(rand_addr(), 8'd7, 1'b0);
    push_cmd(rand_addr(), 8'd2);
    wait_aw(base + 1, "reset_aw_wait");
    tick(2);
    check("pre_reset_wvalid", wvalid, 1'b1);
    rst = 1'b1;
    tick(1);
    check("reset_mid_burst", {awvalid, wvalid, wlast, bready}, 4'b0000);
    rst = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("post_reset_idle", {awvalid, wvalid}, 2'b00);
    end
    check("err_post_reset", reg_axi_tmout_err, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
